// File: rtl/core_test_sequencer_pkg.sv
// Shared types and helpers for the core test sequencer.
// Holds the sequencer state encoding and the port width helper.
package core_test_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CHECK,
        DONE
    } state_t;

    // clog2 that never collapses to a zero-width vector
    function automatic int width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/core_test_checker.sv
// Register-table comparison for the core test sequencer.
// Accumulates mismatches and remembers the first failing index.
module core_test_checker
    import core_test_sequencer_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CW   = 2,
    parameter int EW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            cmp_en,
    input  logic            last,
    input  logic [CW-1:0]   idx,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] expv,
    output logic [EW-1:0]   err_cnt,
    output logic [CW-1:0]   fail_idx,
    output logic            pass
);

    logic miss;

    assign miss = (rdata != expv);

    // Score each compare; pass is only resolved on the final one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt  <= '0;
            fail_idx <= '0;
            pass     <= 1'b0;
        end else if (clear) begin
            err_cnt  <= '0;
            fail_idx <= '0;
            pass     <= 1'b0;
        end else if (cmp_en) begin
            if (miss) begin
                err_cnt <= err_cnt + EW'(1);
                if (err_cnt == '0) begin
                    fail_idx <= idx;
                end
            end
            if (last) begin
                pass <= (err_cnt == '0) && !miss;
            end
        end
    end

endmodule

// File: rtl/core_test_sequencer.sv
// On-chip test controller: load imem, run the core, check registers.
// Control outputs are decoded from state so reset clears them at once.
module core_test_sequencer
    import core_test_sequencer_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 1024,
    parameter int PROG_LEN   = 16,
    parameter int RUN_CYCLES = 10,
    parameter int NUM_CHECKS = 4,
    localparam int PW = width(PROG_LEN),
    localparam int AW = width(IMEM_DEPTH),
    localparam int CW = width(NUM_CHECKS),
    localparam int EW = width(NUM_CHECKS + 1),
    localparam int RW = width(RUN_CYCLES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [PW-1:0]   prog_addr,
    input  logic [XLEN-1:0] prog_data,
    output logic            imem_we,
    output logic [AW-1:0]   imem_addr,
    output logic [XLEN-1:0] imem_wdata,
    output logic            core_reset,
    output logic [CW-1:0]   chk_idx,
    input  logic [4:0]      chk_reg,
    input  logic [XLEN-1:0] chk_exp,
    output logic [4:0]      dbg_raddr,
    input  logic [XLEN-1:0] dbg_rdata,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [EW-1:0]   err_cnt,
    output logic [CW-1:0]   fail_idx
);

    state_t        state;
    state_t        state_n;
    logic [AW-1:0] addr;
    logic [RW-1:0] run_cnt;
    logic [CW-1:0] idx;
    logic          phase_b;
    logic          in_prog;
    logic          accept;
    logic          last_word;
    logic          last_run;
    logic          last_chk;

    assign in_prog   = 32'(addr) < 32'(PROG_LEN);
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_word = (addr == AW'(IMEM_DEPTH - 1));
    assign last_run  = (run_cnt == RW'(RUN_CYCLES - 1));
    assign last_chk  = (idx == CW'(NUM_CHECKS - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and decoded control outputs
    always_comb begin
        state_n    = state;
        prog_addr  = '0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        core_reset = 1'b0;
        chk_idx    = '0;
        dbg_raddr  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_n = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                imem_we   = 1'b1;
                imem_addr = addr;
                if (in_prog) begin
                    prog_addr  = PW'(addr);
                    imem_wdata = prog_data;
                end
                if (last_word) state_n = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                core_reset = 1'b1;
                if (last_run) state_n = CHECK;
            end
            CHECK: begin
                busy      = 1'b1;
                chk_idx   = idx;
                dbg_raddr = chk_reg;
                if (phase_b && last_chk) state_n = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (accept) state_n = LOAD;
            end
            default: state_n = IDLE;
        endcase
    end

    // Load address, run length and check position counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr    <= '0;
            run_cnt <= '0;
            idx     <= '0;
            phase_b <= 1'b0;
        end else begin
            if ((state == LOAD) && (state_n == LOAD)) begin
                addr <= addr + AW'(1);
            end else begin
                addr <= '0;
            end
            if ((state == RUN) && (state_n == RUN)) begin
                run_cnt <= run_cnt + RW'(1);
            end else begin
                run_cnt <= '0;
            end
            if ((state == CHECK) && (state_n == CHECK)) begin
                phase_b <= !phase_b;
                if (phase_b) idx <= idx + CW'(1);
            end else begin
                phase_b <= 1'b0;
                idx     <= '0;
            end
        end
    end

    core_test_checker #(
        .XLEN (XLEN),
        .CW   (CW),
        .EW   (EW)
    ) u_checker (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .cmp_en   ((state == CHECK) && phase_b),
        .last     (last_chk),
        .idx      (idx),
        .rdata    (dbg_rdata),
        .expv     (chk_exp),
        .err_cnt  (err_cnt),
        .fail_idx (fail_idx),
        .pass     (pass)
    );

endmodule
